minefield_generator: RTL and testbench

// - Responder side of the field-fill handshake driven by the game FSM.
// - On fill_start_i it builds a new minesweeper field of the requested size:
//   - clears the board;
//   - places mines at LFSR-random cells;
//   - scans every cell and writes its neighbour-mine count.
// - Holds the finished board on game_field_o for the renderer and game FSM.

---
 rtl/minefield_generator.sv | 208 ++++++++++++++++++++
 tb/tb_minefield_generator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/minefield_generator.sv
// Minesweeper field builder: clears the board, drops LFSR-placed mines, then fills neighbour counts.
// Optional build macro MINEFIELD_SAFE_CENTER_EN keeps the centre 3x3 block free of mines.
module minefield_generator #(
   parameter int unsigned MAX_CELL_WIDTH  = 30,
   parameter int unsigned MAX_CELL_HEIGHT = 16,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int unsigned CELL_X_WIDTH    = $clog2(MAX_CELL_WIDTH),
   parameter int unsigned CELL_Y_WIDTH    = $clog2(MAX_CELL_HEIGHT),
   localparam int unsigned MINES_W        = $clog2(MAX_CELL_WIDTH * MAX_CELL_HEIGHT / 4)
) (
   input  logic                                                      clk,
   input  logic                                                      rst,
   input  logic                                                      fill_start_i,
   input  logic [CELL_X_WIDTH-1:0]                                   field_width_i,
   input  logic [CELL_Y_WIDTH-1:0]                                   field_height_i,
   input  logic [MINES_W-1:0]                                        mines_count_i,
   output logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0][3:0]       game_field_o,
   output logic                                                      fill_busy_o,
   output logic                                                      fill_finished_o
);

   localparam int unsigned XW    = CELL_X_WIDTH + 1;
   localparam int unsigned YW    = CELL_Y_WIDTH + 1;
   localparam int unsigned AreaW = XW + YW;

   localparam logic [XW-1:0] XMax = XW'(MAX_CELL_WIDTH);
   localparam logic [YW-1:0] YMax = YW'(MAX_CELL_HEIGHT);
   localparam logic [XW-1:0] XOne = XW'(1);
   localparam logic [YW-1:0] YOne = YW'(1);
   localparam logic [3:0]    Mine = 4'd10;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StClear = 3'd1;
   localparam logic [2:0] StPlace = 3'd2;
   localparam logic [2:0] StCount = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   logic [MAX_CELL_WIDTH-1:0][MAX_CELL_HEIGHT-1:0][3:0] field_q, field_d;
   logic [2:0]              state_q, state_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic [XW-1:0]           w_q, w_d;
   logic [YW-1:0]           h_q, h_d;
   logic [MINES_W-1:0]      mines_left_q, mines_left_d;
   logic [CELL_X_WIDTH-1:0] scan_x_q, scan_x_d;
   logic [CELL_Y_WIDTH-1:0] scan_y_q, scan_y_d;
   logic                    busy_q, busy_d;
   logic                    finished_q, finished_d;

   logic [XW-1:0]      w_in;
   logic [YW-1:0]      h_in;
   logic [AreaW-1:0]   area, mine_lim;
   logic [MINES_W-1:0] m_in;

   logic [CELL_X_WIDTH-1:0] cx;
   logic [CELL_Y_WIDTH-1:0] cy;
   logic                    in_center;
   logic                    cand_ok;

   logic [XW-1:0] nx;
   logic [YW-1:0] ny;
   logic [3:0]    nb_count;

   // Galois step; runs in every state so the board depends on start timing.
   assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

   assign w_in = ({1'b0, field_width_i} > XMax) ? XMax : {1'b0, field_width_i};
   assign h_in = ({1'b0, field_height_i} > YMax) ? YMax : {1'b0, field_height_i};
   assign area = AreaW'(w_in) * AreaW'(h_in);

   assign cx = lfsr_q[CELL_X_WIDTH-1:0];
   assign cy = lfsr_q[CELL_X_WIDTH +: CELL_Y_WIDTH];

`ifdef MINEFIELD_SAFE_CENTER_EN
   logic [XW-1:0] wc;
   logic [YW-1:0] hc;
   logic          near_x, near_y;

   assign mine_lim  = (area >= AreaW'(9)) ? (area - AreaW'(9)) : '0;
   assign wc        = w_q >> 1;
   assign hc        = h_q >> 1;
   assign near_x    = (({1'b0, cx} + XOne) >= wc) && ({1'b0, cx} <= (wc + XOne));
   assign near_y    = (({1'b0, cy} + YOne) >= hc) && ({1'b0, cy} <= (hc + YOne));
   assign in_center = near_x && near_y;
`else
   assign mine_lim  = area - AreaW'(1);
   assign in_center = 1'b0;
`endif

   assign m_in = (AreaW'(mines_count_i) > mine_lim) ? MINES_W'(mine_lim) : mines_count_i;

   // Short-circuit keeps the field read inside the board when cx/cy are out of range.
   assign cand_ok = ({1'b0, cx} < w_q) && ({1'b0, cy} < h_q) && !in_center &&
                    (field_q[cx][cy] != Mine);

   always_comb begin
      nb_count = '0;
      nx       = '0;
      ny       = '0;
      for (int dx = 0; dx < 3; dx++) begin
         for (int dy = 0; dy < 3; dy++) begin
            // Underflow at the left/top edge wraps past w/h and fails the bounds test.
            nx = {1'b0, scan_x_q} + XW'(dx) - XOne;
            ny = {1'b0, scan_y_q} + YW'(dy) - YOne;
            if (!(dx == 1 && dy == 1) && (nx < w_q) && (ny < h_q) &&
                (field_q[nx[CELL_X_WIDTH-1:0]][ny[CELL_Y_WIDTH-1:0]] == Mine)) begin
               nb_count = nb_count + 4'd1;
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      field_d      = field_q;
      w_d          = w_q;
      h_d          = h_q;
      mines_left_d = mines_left_q;
      scan_x_d     = scan_x_q;
      scan_y_d     = scan_y_q;
      busy_d       = busy_q;
      finished_d   = finished_q;
      case (state_q)
         StIdle: begin
            if (fill_start_i) begin
               w_d          = w_in;
               h_d          = h_in;
               mines_left_d = m_in;
               finished_d   = 1'b0;
               busy_d       = 1'b1;
               state_d      = StClear;
            end
         end
         StClear: begin
            field_d  = '0;
            scan_x_d = '0;
            scan_y_d = '0;
            if (w_q == '0 || h_q == '0) begin
               state_d = StDone;
            end else if (mines_left_q == '0) begin
               state_d = StCount;
            end else begin
               state_d = StPlace;
            end
         end
         StPlace: begin
            if (cand_ok) begin
               field_d[cx][cy] = Mine;
               mines_left_d    = mines_left_q - MINES_W'(1);
               if (mines_left_q == MINES_W'(1)) begin
                  state_d = StCount;
               end
            end
         end
         StCount: begin
            if (field_q[scan_x_q][scan_y_q] != Mine) begin
               field_d[scan_x_q][scan_y_q] = nb_count;
            end
            if ({1'b0, scan_x_q} == (w_q - XOne)) begin
               scan_x_d = '0;
               if ({1'b0, scan_y_q} == (h_q - YOne)) begin
                  state_d = StDone;
               end else begin
                  scan_y_d = scan_y_q + CELL_Y_WIDTH'(1);
               end
            end else begin
               scan_x_d = scan_x_q + CELL_X_WIDTH'(1);
            end
         end
         StDone: begin
            busy_d     = 1'b0;
            finished_d = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         field_q      <= '0;
         lfsr_q       <= LFSR_SEED;
         w_q          <= '0;
         h_q          <= '0;
         mines_left_q <= '0;
         scan_x_q     <= '0;
         scan_y_q     <= '0;
         busy_q       <= 1'b0;
         finished_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         field_q      <= field_d;
         lfsr_q       <= lfsr_d;
         w_q          <= w_d;
         h_q          <= h_d;
         mines_left_q <= mines_left_d;
         scan_x_q     <= scan_x_d;
         scan_y_q     <= scan_y_d;
         busy_q       <= busy_d;
         finished_q   <= finished_d;
      end
   end

   assign game_field_o    = field_q;
   assign fill_busy_o     = busy_q;
   assign fill_finished_o = finished_q;

endmodule

// File: tb/tb_minefield_generator.sv
// Directed bench for minefield_generator: a reference model predicts each board from the LFSR
// state at the start edge; expectations are queued at start and checked when finished rises.
module tb_minefield_generator;

   localparam int Budget = 20000;

   typedef logic [29:0][15:0][3:0] board_t;
   typedef struct {
      string  tag;
      board_t board;
      int     cycles;
      int     mines;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         fill_start_i;
   logic [4:0]   field_width_i;
   logic [3:0]   field_height_i;
   logic [6:0]   mines_count_i;
   board_t       game_field_o;
   logic         fill_busy_o;
   logic         fill_finished_o;

   logic [15:0]  m_lfsr;
   exp_t         sb[$];
   int           n_cmp  = 0;
   int           n_fail = 0;
   int           last_cycles;

   minefield_generator dut (
      .clk             (clk),
      .rst             (rst),
      .fill_start_i    (fill_start_i),
      .field_width_i   (field_width_i),
      .field_height_i  (field_height_i),
      .mines_count_i   (mines_count_i),
      .game_field_o    (game_field_o),
      .fill_busy_o     (fill_busy_o),
      .fill_finished_o (fill_finished_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Reference LFSR: reseeds under reset, otherwise steps on every edge.
   always @(posedge clk) begin
      if (!rst) m_lfsr <= 16'hACE1;
      else      m_lfsr <= step(m_lfsr);
   end

   function automatic int count_val(input board_t b, input logic [3:0] v);
      int n = 0;
      for (int x = 0; x < 30; x++)
         for (int y = 0; y < 16; y++)
            if (b[x][y] == v) n++;
      return n;
   endfunction

   function automatic int count_nonzero(input board_t b);
      int n = 0;
      for (int x = 0; x < 30; x++)
         for (int y = 0; y < 16; y++)
            if (b[x][y] != 4'd0) n++;
      return n;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // l0 is the LFSR value during the start-accept cycle; PLACE candidates begin two steps later.
   task automatic model(input string tag, input logic [15:0] l0, input int wi, input int hi,
                        input int mi, output exp_t e);
      board_t b = '0;
      int w = (wi > 30) ? 30 : wi;
      int h = (hi > 16) ? 16 : hi;
      int area = w * h;
      int lim, m, placed, p, cx, cy, n;
      logic [15:0] s = step(step(l0));
      bit ok;
`ifdef MINEFIELD_SAFE_CENTER_EN
      lim = (area >= 9) ? area - 9 : 0;
`else
      lim = area - 1;
`endif
      m = (mi > lim) ? lim : mi;
      e.tag = tag;
      if (w == 0 || h == 0) begin
         e.board  = '0;
         e.cycles = 3;
         e.mines  = 0;
         return;
      end
      placed = 0;
      p      = 0;
      while (placed < m && p < 200000) begin
         cx = int'(s[4:0]);
         cy = int'(s[8:5]);
         ok = (cx < w) && (cy < h);
`ifdef MINEFIELD_SAFE_CENTER_EN
         if (cx - (w >> 1) <= 1 && (w >> 1) - cx <= 1 &&
             cy - (h >> 1) <= 1 && (h >> 1) - cy <= 1) ok = 1'b0;
`endif
         if (ok && b[cx][cy] != 4'd10) begin
            b[cx][cy] = 4'd10;
            placed++;
         end
         p++;
         s = step(s);
      end
      for (int x = 0; x < w; x++) begin
         for (int y = 0; y < h; y++) begin
            if (b[x][y] != 4'd10) begin
               n = 0;
               for (int dx = -1; dx <= 1; dx++)
                  for (int dy = -1; dy <= 1; dy++)
                     if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < w &&
                         y + dy >= 0 && y + dy < h && b[x+dx][y+dy] == 4'd10) n++;
               b[x][y] = 4'(n);
            end
         end
      end
      e.board  = b;
      e.cycles = 3 + p + area;
      e.mines  = m;
   endtask

   task automatic run_gen(input string tag, input int w, input int h, input int m,
                          input int pulse_at);
      exp_t e;
      exp_t got;
      int   cycles;
      bit   busy_ok;
      @(negedge clk);
      field_width_i  = 5'(w);
      field_height_i = 4'(h);
      mines_count_i  = 7'(m);
      fill_start_i   = 1'b1;
      model(tag, m_lfsr, w, h, m, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      fill_start_i = 1'b0;
      cycles       = 1;
      busy_ok      = 1'b1;
      check({tag, " finished_low_after_start"}, 64'(fill_finished_o), 64'd0);
      while (!fill_finished_o && cycles < Budget) begin
         if (fill_busy_o !== 1'b1) busy_ok = 1'b0;
         if (cycles == pulse_at) fill_start_i = 1'b1;
         @(posedge clk);
         #1;
         fill_start_i = 1'b0;
         cycles++;
      end
      last_cycles = cycles;
      got = sb.pop_front();
      check({got.tag, " busy_while_generating"}, 64'(busy_ok), 64'd1);
      check({got.tag, " finished"}, 64'(fill_finished_o), 64'd1);
      check({got.tag, " busy_done"}, 64'(fill_busy_o), 64'd0);
      check({got.tag, " cycles"}, 64'(cycles), 64'(got.cycles));
      check({got.tag, " mines"}, 64'(count_val(game_field_o, 4'd10)), 64'(got.mines));
      for (int x = 0; x < 30; x++)
         check($sformatf("%s col%0d", got.tag, x), game_field_o[x], got.board[x]);
   endtask

   initial begin
      rst            = 1'b0;
      fill_start_i   = 1'b0;
      field_width_i  = '0;
      field_height_i = '0;
      mines_count_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 64'(fill_busy_o), 64'd0);
      check("reset finished", 64'(fill_finished_o), 64'd0);
      check("reset board", 64'(count_nonzero(game_field_o)), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Start pulse mid-PLACE must be ignored; timing and board stay those of one generation.
      run_gen("g8x8", 8, 8, 10, 5);
      repeat (10) @(posedge clk);
      #1;
      check("idle finished_held", 64'(fill_finished_o), 64'd1);
      check("idle busy", 64'(fill_busy_o), 64'd0);

      run_gen("g30x15", 30, 15, 119, 0);

      run_gen("g4x4", 4, 4, 0, 0);
      check("g4x4 fixed_latency", 64'(last_cycles), 64'd19);
      check("g4x4 all_zero", 64'(count_nonzero(game_field_o)), 64'd0);

      run_gen("g2x2", 2, 2, 100, 0);
      check("g2x2 clamped_mines", 64'(count_val(game_field_o, 4'd10)), 64'd3);
      check("g2x2 free_cell_is_3", 64'(count_val(game_field_o, 4'd3)), 64'd1);

      run_gen("clamp_w31", 31, 3, 5, 0);
      run_gen("h0", 5, 0, 3, 0);

      // Reset during PLACE.
      @(negedge clk);
      field_width_i  = 5'd30;
      field_height_i = 4'd15;
      mines_count_i  = 7'd119;
      fill_start_i   = 1'b1;
      @(posedge clk);
      #1;
      fill_start_i = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("mid_place busy", 64'(fill_busy_o), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("mid_reset board", 64'(count_nonzero(game_field_o)), 64'd0);
      check("mid_reset busy", 64'(fill_busy_o), 64'd0);
      check("mid_reset finished", 64'(fill_finished_o), 64'd0);
      run_gen("after_reset", 6, 5, 7, 0);

`ifdef MINEFIELD_SAFE_CENTER_EN
      run_gen("safe9x9", 9, 9, 40, 0);
      begin
         int c = 0;
         for (int x = 3; x <= 5; x++)
            for (int y = 3; y <= 5; y++)
               if (game_field_o[x][y] == 4'd10) c++;
         check("safe9x9 centre_clear", 64'(c), 64'd0);
      end
`endif

      check("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
